sd_spi_responder: RTL



---
 rtl/sd_pkg.sv | 36 +++
 rtl/sd_crc7.sv | 25 ++
 rtl/sd_spi_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD SPI-mode constants, state encoding and CRC7 step
// Used by both the card model and the init host so command indices,
// R1 bit positions and the CRC7 polynomial are defined in one place.
package sd_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC     = 3;

  localparam int FRAME_LEN = 48;
  localparam int R1_LEN    = 8;
  localparam int R7_LEN    = 40;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift-out
  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_RECV,
    ST_CHECK,
    ST_WAIT_NCR,
    ST_SEND
  } sd_state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = crc[6] ^ bit_in;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - serial CRC7 accumulator, one message bit per enabled cycle
// Ports: clk, res_n (async active-low), clear (sync zero, wins over enable),
//        enable (fold bit_in into crc), bit_in, crc[6:0] (running remainder).
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD card SPI-mode init responder (CMD0/8/55/ACMD41)
// Ports: clk (also SPI bit clock), res_n (async active-low), sd_cs (active low),
//        MOSI_bit (command in, MSB first), MISO_bit (response out, idles 1),
//        card_idle (R1 idle bit), cmd_valid (accept pulse), cmd_index, cmd_arg.
module sd_spi_responder
  import sd_pkg::*;
#(
  parameter int NCR_BYTES      = 1,
  parameter int ACMD41_RETRIES = 2,
  parameter bit CRC_CHECK      = 1'b1
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        sd_cs,
  input  logic        MOSI_bit,
  output logic        MISO_bit,
  output logic        card_idle,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  sd_state_t   state, next_state;
  logic [46:0] frame;      // bits 46..0; bit 47 is always the 0 start bit
  logic [5:0]  bit_cnt;
  logic [5:0]  ncr_cnt;
  logic [5:0]  send_cnt;
  logic [39:0] resp;       // MSB-aligned, shifted out from bit 39
  logic        app_flag;
  logic [7:0]  acmd_cnt;
  logic [6:0]  crc;

  logic        frame_ok, crc_bad, long_resp;
  logic [5:0]  idx;
  logic [7:0]  r1;
  logic [39:0] resp_next;
  logic        idle_next, app_next;
  logic [7:0]  acmd_next;

  // Leading start bit 0 leaves a cleared CRC at 0, so folding only 46..8 suffices.
  sd_crc7 u_crc7 (
    .clk    (clk),
    .res_n  (res_n),
    .clear  (state == ST_HUNT),
    .enable (state == ST_RECV && bit_cnt >= 6'd8),
    .bit_in (MOSI_bit),
    .crc    (crc)
  );

  assign idx      = frame[45:40];
  assign frame_ok = frame[46] & frame[0];
  assign crc_bad  = CRC_CHECK && (idx == CMD0 || idx == CMD8) && (crc != frame[7:1]);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= ST_HUNT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_HUNT:     if (!MOSI_bit) next_state = ST_RECV;
      ST_RECV:     if (bit_cnt == 6'd0) next_state = ST_CHECK;
      ST_CHECK:    next_state = frame_ok ? ST_WAIT_NCR : ST_HUNT;
      ST_WAIT_NCR: if (ncr_cnt == 6'd0) next_state = ST_SEND;
      ST_SEND:     if (send_cnt == 6'd0) next_state = ST_HUNT;
      default:     next_state = ST_HUNT;
    endcase
    if (sd_cs) next_state = ST_HUNT;
  end

  // Response and card-state update decided in CHECK; r1 starts from idle-before-update.
  always_comb begin
    r1          = 8'h00;
    r1[R1_IDLE] = card_idle;
    long_resp   = 1'b0;
    idle_next   = card_idle;
    acmd_next   = acmd_cnt;
    app_next    = 1'b0;
    if (crc_bad) begin
      r1[R1_CRC] = 1'b1;
      app_next   = app_flag;
    end else begin
      case (idx)
        CMD0: begin
          idle_next = 1'b1;
          acmd_next = 8'd0;
          r1        = 8'h01;
        end
        CMD8:  long_resp = 1'b1;
        CMD55: app_next  = 1'b1;
        CMD41: begin
          if (!app_flag) begin
            r1[R1_ILLEGAL] = 1'b1;
          end else if (int'(acmd_cnt) < ACMD41_RETRIES) begin
            acmd_next = acmd_cnt + 8'd1;
            r1        = 8'h01;
          end else begin
            idle_next = 1'b0;
            r1        = 8'h00;
          end
        end
        default: r1[R1_ILLEGAL] = 1'b1;
      endcase
    end
    resp_next = long_resp ? {r1, 20'h00000, frame[19:8]} : {r1, 32'h0};
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      frame     <= '0;
      bit_cnt   <= '0;
      ncr_cnt   <= '0;
      send_cnt  <= '0;
      resp      <= '0;
      app_flag  <= 1'b0;
      acmd_cnt  <= '0;
      MISO_bit  <= 1'b1;
      card_idle <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_index <= '0;
      cmd_arg   <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (sd_cs) begin
        MISO_bit <= 1'b1;
      end else begin
        case (state)
          ST_HUNT: begin
            bit_cnt  <= 6'(FRAME_LEN - 2);
            MISO_bit <= 1'b1;
          end
          ST_RECV: begin
            frame   <= {frame[45:0], MOSI_bit};
            bit_cnt <= bit_cnt - 6'd1;
          end
          ST_CHECK: begin
            if (frame_ok) begin
              resp     <= resp_next;
              send_cnt <= long_resp ? 6'(R7_LEN - 1) : 6'(R1_LEN - 1);
              ncr_cnt  <= 6'(8 * NCR_BYTES - 1);
              if (!crc_bad) begin
                cmd_valid <= 1'b1;
                cmd_index <= idx;
                cmd_arg   <= frame[39:8];
                card_idle <= idle_next;
                acmd_cnt  <= acmd_next;
                app_flag  <= app_next;
              end
            end
          end
          ST_WAIT_NCR: begin
            if (ncr_cnt == 6'd0) begin
              MISO_bit <= resp[39];
              resp     <= {resp[38:0], 1'b0};
            end else begin
              ncr_cnt <= ncr_cnt - 6'd1;
            end
          end
          ST_SEND: begin
            if (send_cnt == 6'd0) begin
              MISO_bit <= 1'b1;
            end else begin
              MISO_bit <= resp[39];
              resp     <= {resp[38:0], 1'b0};
              send_cnt <= send_cnt - 6'd1;
            end
          end
          default: MISO_bit <= 1'b1;
        endcase
      end
    end
  end

endmodule
